store_aligner: RTL and testbench
================================

STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of clk.
REQ-002 clk  input  1  core clock.
REQ-003 rstn  input  1  synchronous active-low reset.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_addr  input  64  byte address of the store.
REQ-007 req_data  input  64  store value, LSB-aligned (rs2).
REQ-008 req_width  input  4  store size in bytes: 1, 2, 4 or 8.
REQ-009 mem_wen  output  1  memory write beat valid.
REQ-010 mem_ready  input  1  memory accepts the current beat.
REQ-011 mem_addr  output  64  doubleword-aligned beat address (bits [2:0] = 0).
REQ-012 mem_wdata  output  64  byte-lane-positioned write data.
REQ-013 mem_wmask  output  8  byte enables, bit i = byte lane i.
REQ-014 done  output  1  one-cycle pulse: store fully written.
REQ-015 err  output  1  one-cycle pulse: illegal req_width, no write issued.

Function
REQ-016 States SHALL be IDLE, BEAT0, BEAT1, FIN.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-018 On acceptance the block SHALL register off = req_addr[2:0], base = {req_addr[63:3], 3'b0}, data128 = zero-extended req_data << (8*off), mask16 = ((1 << req_width) - 1) << off.
REQ-019 Legal width: IDLE -> BEAT0; illegal width (not 1/2/4/8): IDLE -> FIN with err = 1 in FIN, done = 0, mem_wen never asserted.
REQ-020 BEAT0: mem_wen = 1, mem_addr = base, mem_wdata = data128[63:0], mem_wmask = mask16[7:0].
REQ-021 BEAT0 handshake (mem_ready = 1): if mask16[15:8] != 0 -> BEAT1, else -> FIN.
REQ-022 BEAT1: mem_wen = 1, mem_addr = base + 8 (64-bit wrap permitted), mem_wdata = data128[127:64], mem_wmask = mask16[15:8]; on mem_ready -> FIN.
REQ-023 While mem_wen = 1 and mem_ready = 0, mem_addr/mem_wdata/mem_wmask SHALL hold stable and mem_wen SHALL stay 1.
REQ-024 FIN SHALL last exactly one cycle, assert done (legal path) or err (illegal path), then return to IDLE.
REQ-025 Latency: first mem_wen in the cycle after acceptance; done one cycle after the final beat handshake; minimum 3 cycles per aligned store, 4 per split store.
REQ-026 Bytes outside the mask SHALL be driven 0 in mem_wdata.
REQ-027 Outside BEAT0/BEAT1: mem_wen = 0, mem_wmask = 0, mem_wdata = 0, mem_addr = 0.
REQ-028 req_data/req_addr changes after acceptance SHALL NOT affect beats in flight.

Reset
REQ-029 rstn = 0 at a clock edge SHALL force IDLE regardless of state, including mid-beat; an in-flight beat is abandoned without done.
REQ-030 Reset values: req_ready = 0 during reset, 1 in the first cycle after release; mem_wen = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 0, done = 0, err = 0; all internal registers cleared.

Structure
REQ-031 The state enum (IDLE/BEAT0/BEAT1/FIN) SHALL live in the shared CorePack package.
REQ-032 Width-to-mask decode and shift SHALL be a sub-module store_lane_gen (combinational: off, width, data -> data128, mask16, legal).
REQ-033 All other logic SHALL be a single sequential FSM in store_aligner.

Verification
REQ-034 SD addr 0x1000, data 0x1122334455667788, mem_ready = 1 -> one beat addr 0x1000, wdata 0x1122334455667788, wmask 0xFF; done 1 cycle later.
REQ-035 SB addr 0x1005, data 0xAB -> one beat addr 0x1000, wdata 0x0000AB0000000000, wmask 0x20.
REQ-036 SW addr 0x1006, data 0xDEADBEEF -> beat0 addr 0x1000, wdata 0xBEEF000000000000, wmask 0xC0; beat1 addr 0x1008, wdata 0x000000000000DEAD, wmask 0x03; single done.
REQ-037 SH addr 0x2002, mem_ready low 3 cycles -> mem_wen and outputs held constant 3 cycles, done 1 cycle after the handshake.
REQ-038 req_width = 3 -> err pulse, no mem_wen, req_ready high again 2 cycles after acceptance.
REQ-039 rstn = 0 during BEAT1 of a split store -> next cycle all outputs at reset values, no done; new request accepted normally afterwards.

Source files
------------

// File: rtl/store_aligner_pkg.sv
// Shared core types: store FSM states and the per-store context latched at acceptance.
// Pure type/constant definitions; no logic, no latency, no flow control.
package CorePack;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FIN   = 2'd3
    } store_state_t;

    typedef struct packed {
        logic [60:0]  base;   // doubleword index of the first beat
        logic [127:0] data;   // lane-positioned data across two doublewords
        logic [15:0]  mask;   // byte enables across two doublewords
        logic         legal;  // width was 1/2/4/8
    } store_ctx_t;

endpackage

// File: rtl/store_aligner_if.sv
// Store request and memory write-beat bundle between a requester (master) and the aligner (slave).
// Wires only; valid/ready on the request side, wen/ready on the memory side.
interface store_aligner_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  req_width;
    logic        mem_wen;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        done;
    logic        err;

    modport master (
        output req_valid, req_addr, req_data, req_width, mem_ready,
        input  req_ready, mem_wen, mem_addr, mem_wdata, mem_wmask, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_width, mem_ready,
        output req_ready, mem_wen, mem_addr, mem_wdata, mem_wmask, done, err
    );
endinterface

// File: rtl/store_lane_gen.sv
// Width decode and byte-lane shift of a store into a two-doubleword window.
// Combinational, zero latency; no flow control.
module store_lane_gen (
    input  logic [2:0]   off,
    input  logic [3:0]   width,
    input  logic [63:0]  data,
    output logic [127:0] data128,
    output logic [15:0]  mask16,
    output logic         legal
);
    logic [7:0]  mask8;
    logic [63:0] data_m;

    always_comb begin
        mask8 = 8'h00;
        legal = 1'b1;
        case (width)
            4'd1:    mask8 = 8'h01;
            4'd2:    mask8 = 8'h03;
            4'd4:    mask8 = 8'h0F;
            4'd8:    mask8 = 8'hFF;
            default: legal = 1'b0;
        endcase
        // Upper rs2 bytes beyond the store width must never reach the bus.
        for (int i = 0; i < 8; i++) begin
            data_m[i*8 +: 8] = mask8[i] ? data[i*8 +: 8] : 8'h00;
        end
        data128 = {64'h0, data_m} << {off, 3'b000};
        mask16  = {8'h00, mask8} << off;
    end
endmodule

// File: rtl/store_aligner.sv
// Splits a byte-addressed store into one or two doubleword-aligned masked write beats.
// First beat the cycle after acceptance, done/err one cycle after the last beat; beats hold while mem_ready is low.
module store_aligner
    import CorePack::*;
(
    input  logic           clk,
    input  logic           rstn,
    store_aligner_if.slave bus
);
    store_state_t state, state_nxt;
    store_ctx_t   ctx;
    logic [127:0] lane_data128;
    logic [15:0]  lane_mask16;
    logic         lane_legal;
    logic         accept;

    store_lane_gen u_lane_gen (
        .off     (bus.req_addr[2:0]),
        .width   (bus.req_width),
        .data    (bus.req_data),
        .data128 (lane_data128),
        .mask16  (lane_mask16),
        .legal   (lane_legal)
    );

    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            ctx   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ctx <= '{base:  bus.req_addr[63:3],
                         data:  lane_data128,
                         mask:  lane_mask16,
                         legal: lane_legal};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = lane_legal ? BEAT0 : FIN;
            BEAT0:   if (bus.mem_ready) state_nxt = (|ctx.mask[15:8]) ? BEAT1 : FIN;
            BEAT1:   if (bus.mem_ready) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // Ready is gated by rstn so nothing is accepted while reset is held.
        bus.req_ready = (state == IDLE) && rstn;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = 64'h0;
        bus.mem_wdata = 64'h0;
        bus.mem_wmask = 8'h00;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state)
            BEAT0: begin
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = {ctx.base, 3'b000};
                bus.mem_wdata = ctx.data[63:0];
                bus.mem_wmask = ctx.mask[7:0];
            end
            BEAT1: begin
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = {ctx.base, 3'b000} + 64'd8;
                bus.mem_wdata = ctx.data[127:64];
                bus.mem_wmask = ctx.mask[15:8];
            end
            FIN: begin
                bus.done = ctx.legal;
                bus.err  = !ctx.legal;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_store_aligner.sv
// Randomized and directed bench for store_aligner against a byte-level store model.
module tb_store_aligner;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    store_aligner_if sif ();

    store_aligner dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (sif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-by-byte placement of a store into doubleword beats; returns beat count, 0 when illegal.
    function automatic int gen(input logic [63:0] a, input logic [63:0] d, input logic [3:0] w,
                               output logic [1:0][63:0] ba, output logic [1:0][63:0] bd,
                               output logic [1:0][7:0] bm);
        int n = 0;
        logic [63:0] first, x, dw;
        int k, lane;
        ba = '0; bd = '0; bm = '0;
        if (!(w == 4'd1 || w == 4'd2 || w == 4'd4 || w == 4'd8)) return 0;
        first = {a[63:3], 3'b000};
        for (int i = 0; i < int'(w); i++) begin
            x    = a + 64'(i);
            dw   = {x[63:3], 3'b000};
            k    = (dw == first) ? 0 : 1;
            lane = int'(x[2:0]);
            bd[k][lane*8 +: 8] = d[i*8 +: 8];
            bm[k][lane]        = 1'b1;
            ba[k]              = dw;
            if (k + 1 > n) n = k + 1;
        end
        return n;
    endfunction

    // Protocol-level model: 0 = waiting for a request, 1 = issuing beats, 2 = completion cycle.
    int m_st = 0;
    int m_n = 0;
    int m_idx = 0;
    logic m_err = 1'b0;
    logic [1:0][63:0] m_ba, m_bd;
    logic [1:0][7:0]  m_bm;

    always @(negedge clk) begin
        chk("req_ready", {63'h0, sif.req_ready}, {63'h0, (m_st == 0) && rstn});
        if (m_st == 1) begin
            chk("mem_wen",   {63'h0, sif.mem_wen}, 64'h1);
            chk("mem_addr",  sif.mem_addr, m_ba[m_idx[0]]);
            chk("mem_wdata", sif.mem_wdata, m_bd[m_idx[0]]);
            chk("mem_wmask", {56'h0, sif.mem_wmask}, {56'h0, m_bm[m_idx[0]]});
        end else begin
            chk("mem_wen_idle",   {63'h0, sif.mem_wen}, 64'h0);
            chk("mem_addr_idle",  sif.mem_addr, 64'h0);
            chk("mem_wdata_idle", sif.mem_wdata, 64'h0);
            chk("mem_wmask_idle", {56'h0, sif.mem_wmask}, 64'h0);
        end
        chk("done", {63'h0, sif.done}, {63'h0, (m_st == 2) && !m_err});
        chk("err",  {63'h0, sif.err},  {63'h0, (m_st == 2) && m_err});

        if (!rstn) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (sif.req_valid) begin
                    m_n   = gen(sif.req_addr, sif.req_data, sif.req_width, m_ba, m_bd, m_bm);
                    m_err = (m_n == 0);
                    m_idx = 0;
                    m_st  = m_err ? 2 : 1;
                end
                1: if (sif.mem_ready) begin
                    m_idx++;
                    if (m_idx == m_n) m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] d,
                         input logic [3:0] w, input logic r);
        sif.req_valid = v;
        sif.req_addr  = a;
        sif.req_data  = d;
        sif.req_width = w;
        sif.mem_ready = r;
    endtask

    task automatic drive_idle(input logic r);
        drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), r);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !sif.req_ready; i++) begin
            drive_idle(1'b1);
            step();
        end
        chk("wait_idle", {63'h0, sif.req_ready}, 64'h1);
    endtask

    logic [1:0][63:0] pa, pd;
    logic [1:0][7:0]  pm;
    int pn;

    initial begin
        rstn = 1'b0;
        drive(1'b0, 64'h0, 64'h0, 4'd0, 1'b0);

        // Pin the model with hand-worked placements.
        pn = gen(64'h1000, 64'h1122334455667788, 4'd8, pa, pd, pm);
        chk("model_sd_n", 64'(pn), 64'd1);
        chk("model_sd_addr", pa[0], 64'h1000);
        chk("model_sd_data", pd[0], 64'h1122334455667788);
        chk("model_sd_mask", {56'h0, pm[0]}, 64'hFF);
        pn = gen(64'h1005, 64'hAB, 4'd1, pa, pd, pm);
        chk("model_sb_n", 64'(pn), 64'd1);
        chk("model_sb_data", pd[0], 64'h0000AB0000000000);
        chk("model_sb_mask", {56'h0, pm[0]}, 64'h20);
        pn = gen(64'h1006, 64'hDEADBEEF, 4'd4, pa, pd, pm);
        chk("model_sw_n", 64'(pn), 64'd2);
        chk("model_sw_b0", pd[0], 64'hBEEF000000000000);
        chk("model_sw_m0", {56'h0, pm[0]}, 64'hC0);
        chk("model_sw_a1", pa[1], 64'h1008);
        chk("model_sw_b1", pd[1], 64'h000000000000DEAD);
        chk("model_sw_m1", {56'h0, pm[1]}, 64'h03);
        pn = gen(64'h1000, 64'h55, 4'd3, pa, pd, pm);
        chk("model_w3_n", 64'(pn), 64'd0);

        repeat (3) step();
        rstn = 1'b1;
        step();

        // Doubleword store, memory always ready.
        wait_idle();
        drive(1'b1, 64'h1000, 64'h1122334455667788, 4'd8, 1'b1);
        step();
        drive_idle(1'b1);
        chk("sd_addr", sif.mem_addr, 64'h1000);
        chk("sd_wdata", sif.mem_wdata, 64'h1122334455667788);
        chk("sd_wmask", {56'h0, sif.mem_wmask}, 64'hFF);
        step();
        chk("sd_done", {63'h0, sif.done}, 64'h1);

        // Byte store with garbage in the upper rs2 bytes.
        wait_idle();
        drive(1'b1, 64'h1005, 64'hFFFF_FFFF_FFFF_FFAB, 4'd1, 1'b1);
        step();
        drive_idle(1'b1);
        chk("sb_wdata", sif.mem_wdata, 64'h0000AB0000000000);
        chk("sb_wmask", {56'h0, sif.mem_wmask}, 64'h20);

        // Word store crossing a doubleword.
        wait_idle();
        drive(1'b1, 64'h1006, 64'hDEADBEEF, 4'd4, 1'b1);
        step();
        drive_idle(1'b1);
        chk("sw_b0_wdata", sif.mem_wdata, 64'hBEEF000000000000);
        step();
        chk("sw_b1_addr", sif.mem_addr, 64'h1008);
        chk("sw_b1_wdata", sif.mem_wdata, 64'h000000000000DEAD);
        chk("sw_b1_wmask", {56'h0, sif.mem_wmask}, 64'h03);
        step();
        chk("sw_done", {63'h0, sif.done}, 64'h1);

        // Halfword store held off by memory for three cycles.
        wait_idle();
        drive(1'b1, 64'h2002, 64'h5A5A, 4'd2, 1'b0);
        step();
        drive_idle(1'b0);
        repeat (3) step();
        chk("sh_stall_wen", {63'h0, sif.mem_wen}, 64'h1);
        chk("sh_stall_wdata", sif.mem_wdata, 64'h000000005A5A0000);
        drive_idle(1'b1);
        step();
        chk("sh_done", {63'h0, sif.done}, 64'h1);

        // Illegal width.
        wait_idle();
        drive(1'b1, 64'h3000, 64'h1234, 4'd3, 1'b1);
        step();
        drive_idle(1'b1);
        chk("w3_err", {63'h0, sif.err}, 64'h1);
        step();
        chk("w3_ready_again", {63'h0, sif.req_ready}, 64'h1);

        // Reset during the second beat of a split store.
        wait_idle();
        drive(1'b1, 64'h1006, 64'hDEADBEEF, 4'd4, 1'b1);
        step();
        drive_idle(1'b1);
        step();
        chk("rst_in_beat1", sif.mem_addr, 64'h1008);
        drive_idle(1'b0);
        rstn = 1'b0;
        step();
        chk("rst_wen", {63'h0, sif.mem_wen}, 64'h0);
        chk("rst_done", {63'h0, sif.done}, 64'h0);
        rstn = 1'b1;
        step();
        chk("rst_ready", {63'h0, sif.req_ready}, 64'h1);
        drive(1'b1, 64'h1000, 64'h1122334455667788, 4'd8, 1'b1);
        step();
        drive_idle(1'b1);
        chk("post_rst_wdata", sif.mem_wdata, 64'h1122334455667788);

        // Random traffic: addresses near wrap, mixed widths, backpressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] a;
            logic [3:0]  w;
            case ($urandom % 4)
                0:       a = {$urandom, $urandom};
                1:       a = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom % 8);
                default: a = {32'h0, $urandom};
            endcase
            if ($urandom % 10 < 8) w = 4'(1 << ($urandom % 4));
            else                   w = 4'($urandom);
            drive(($urandom % 3) != 0, a, {$urandom, $urandom}, w, ($urandom % 4) != 0);
            rstn = ($urandom % 200) != 0;
            step();
        end
        rstn = 1'b1;
        drive_idle(1'b1);
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
